// File: rtl/cp0_exception_unit.sv
`default_nettype none
// ============================================================================
// cp0_exception_unit : CP0 register file, COUNT/COMPARE timer and precise
//                      exception / ERET redirect control at pipeline commit.
// Revision: 1.0
// ============================================================================
module cp0_exception_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'hbfc00380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cm_valid,
    input  logic [31:0] cm_pc,
    input  logic        cm_bd,
    input  logic        cm_interrupt,
    input  logic        cm_inst_addr_err,
    input  logic        cm_no_inst,
    input  logic        cm_syscall,
    input  logic        cm_break,
    input  logic        cm_ov,
    input  logic        cm_load_addr_err,
    input  logic        cm_store_addr_err,
    input  logic [31:0] cm_data_addr,
    input  logic        cm_eret,
    input  logic        cm_mtc0,
    input  logic [4:0]  cm_cp0_addr,
    input  logic [31:0] cm_wdata,
    input  logic [5:0]  hw_int,
    output logic [31:0] cp0_status,
    output logic [31:0] cp0_cause,
    output logic [31:0] cp0_compare,
    output logic [31:0] cp0_count,
    output logic [31:0] cp0_epc,
    output logic [31:0] cp0_badvaddr,
    output logic        int_req,
    output logic        flush,
    output logic [31:0] flush_pc
);

    localparam logic [4:0] C_ADDR_COUNT   = 5'd9;
    localparam logic [4:0] C_ADDR_COMPARE = 5'd11;
    localparam logic [4:0] C_ADDR_STATUS  = 5'd12;
    localparam logic [4:0] C_ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] C_ADDR_EPC     = 5'd14;

    localparam logic [4:0] C_EXC_INT  = 5'd0;
    localparam logic [4:0] C_EXC_ADEL = 5'd4;
    localparam logic [4:0] C_EXC_ADES = 5'd5;
    localparam logic [4:0] C_EXC_SYS  = 5'd8;
    localparam logic [4:0] C_EXC_BP   = 5'd9;
    localparam logic [4:0] C_EXC_RI   = 5'd10;
    localparam logic [4:0] C_EXC_OV   = 5'd12;

    localparam logic [1:0] C_BAD_NONE = 2'd0;
    localparam logic [1:0] C_BAD_PC   = 2'd1;
    localparam logic [1:0] C_BAD_DATA = 2'd2;

    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic        r_ti;
    logic [5:0]  r_ip_hw;
    logic [1:0]  r_ip_sw;
    logic [4:0]  r_exccode;
    logic [31:0] r_compare;
    logic [31:0] r_count;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic        r_tick;

    logic        w_exc;
    logic        w_eret;
    logic        w_mtc0;
    logic [4:0]  w_exccode;
    logic [1:0]  w_bad_sel;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_compare;
    logic        w_wr_count;
    logic        w_wr_epc;
    logic [31:0] w_count_next;
    logic        w_ti_next;

    assign w_exc = cm_valid & (cm_interrupt | cm_inst_addr_err | cm_no_inst | cm_syscall |
                               cm_break | cm_ov | cm_load_addr_err | cm_store_addr_err);
    assign w_eret = cm_valid & cm_eret & ~w_exc;
    // An excepting instruction never retires, so its MTC0 is dropped.
    assign w_mtc0 = cm_valid & cm_mtc0 & ~w_exc;

    assign w_wr_status  = w_mtc0 & (cm_cp0_addr == C_ADDR_STATUS);
    assign w_wr_cause   = w_mtc0 & (cm_cp0_addr == C_ADDR_CAUSE);
    assign w_wr_compare = w_mtc0 & (cm_cp0_addr == C_ADDR_COMPARE);
    assign w_wr_count   = w_mtc0 & (cm_cp0_addr == C_ADDR_COUNT);
    assign w_wr_epc     = w_mtc0 & (cm_cp0_addr == C_ADDR_EPC);

    always_comb begin
        w_exccode = C_EXC_INT;
        w_bad_sel = C_BAD_NONE;
        if (cm_interrupt) begin
            w_exccode = C_EXC_INT;
        end else if (cm_inst_addr_err) begin
            w_exccode = C_EXC_ADEL;
            w_bad_sel = C_BAD_PC;
        end else if (cm_no_inst) begin
            w_exccode = C_EXC_RI;
        end else if (cm_ov) begin
            w_exccode = C_EXC_OV;
        end else if (cm_syscall) begin
            w_exccode = C_EXC_SYS;
        end else if (cm_break) begin
            w_exccode = C_EXC_BP;
        end else if (cm_load_addr_err) begin
            w_exccode = C_EXC_ADEL;
            w_bad_sel = C_BAD_DATA;
        end else if (cm_store_addr_err) begin
            w_exccode = C_EXC_ADES;
            w_bad_sel = C_BAD_DATA;
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (w_wr_count) begin
            w_count_next = cm_wdata;
        end else if (r_tick) begin
            w_count_next = r_count + 32'd1;
        end
    end

    // TI matches on the value COUNT is about to take; a COMPARE write clears it outright.
    assign w_ti_next = w_wr_compare ? 1'b0
                     : (r_ti | ((w_count_next == r_compare) && (r_compare != 32'd0)));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_im       <= 8'd0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ti       <= 1'b0;
            r_ip_hw    <= 6'd0;
            r_ip_sw    <= 2'd0;
            r_exccode  <= 5'd0;
            r_compare  <= 32'd0;
            r_count    <= 32'd0;
            r_epc      <= 32'd0;
            r_badvaddr <= 32'd0;
            r_tick     <= 1'b0;
        end else begin
            r_tick  <= w_wr_count ? 1'b0 : ~r_tick;
            r_count <= w_count_next;
            r_ti    <= w_ti_next;
            r_ip_hw <= {hw_int[5] | w_ti_next, hw_int[4:0]};

            if (w_wr_status) begin
                r_im <= cm_wdata[15:8];
                r_ie <= cm_wdata[0];
            end
            if (w_exc) begin
                r_exl <= 1'b1;
            end else if (w_eret) begin
                r_exl <= 1'b0;
            end else if (w_wr_status) begin
                r_exl <= cm_wdata[1];
            end

            if (w_wr_cause) begin
                r_ip_sw <= cm_wdata[9:8];
            end
            if (w_wr_compare) begin
                r_compare <= cm_wdata;
            end

            if (w_exc) begin
                r_exccode <= w_exccode;
                if (!r_exl) begin
                    r_epc <= cm_bd ? (cm_pc - 32'd4) : cm_pc;
                    r_bd  <= cm_bd;
                end
            end else if (w_wr_epc) begin
                r_epc <= cm_wdata;
            end

            if (w_exc && (w_bad_sel == C_BAD_PC)) begin
                r_badvaddr <= cm_pc;
            end else if (w_exc && (w_bad_sel == C_BAD_DATA)) begin
                r_badvaddr <= cm_data_addr;
            end
        end
    end

    assign cp0_status   = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
    assign cp0_cause    = {r_bd, r_ti, 14'd0, r_ip_hw, r_ip_sw, 1'b0, r_exccode, 2'b00};
    assign cp0_compare  = r_compare;
    assign cp0_count    = r_count;
    assign cp0_epc      = r_epc;
    assign cp0_badvaddr = r_badvaddr;

    assign int_req  = r_ie & ~r_exl & (|({r_ip_hw, r_ip_sw} & r_im));
    assign flush    = resetn & (w_exc | w_eret);
    assign flush_pc = w_eret ? r_epc : EXC_VECTOR;

endmodule
`default_nettype wire

// File: tb/tb_cp0_exception_unit.sv
`default_nettype none
// ============================================================================
// tb_cp0_exception_unit : directed scoreboard bench for cp0_exception_unit.
// Revision: 1.0
// ============================================================================
module tb_cp0_exception_unit;

    localparam logic [31:0] C_VEC = 32'hbfc00380;

    localparam int SEL_STATUS   = 0;
    localparam int SEL_CAUSE    = 1;
    localparam int SEL_COMPARE  = 2;
    localparam int SEL_COUNT    = 3;
    localparam int SEL_EPC      = 4;
    localparam int SEL_BADVADDR = 5;
    localparam int SEL_INTREQ   = 6;
    localparam int SEL_FLUSH    = 7;
    localparam int SEL_FLUSHPC  = 8;
    localparam int SEL_TI       = 9;
    localparam int SEL_IP15     = 10;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cm_valid, cm_bd, cm_interrupt, cm_inst_addr_err, cm_no_inst;
    logic        cm_syscall, cm_break, cm_ov, cm_load_addr_err, cm_store_addr_err;
    logic        cm_eret, cm_mtc0;
    logic [31:0] cm_pc, cm_data_addr, cm_wdata;
    logic [4:0]  cm_cp0_addr;
    logic [5:0]  hw_int;
    logic [31:0] cp0_status, cp0_cause, cp0_compare, cp0_count, cp0_epc, cp0_badvaddr;
    logic        int_req, flush;
    logic [31:0] flush_pc;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    cp0_exception_unit #(.EXC_VECTOR(C_VEC)) dut (
        .clk(clk), .resetn(resetn),
        .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_bd(cm_bd),
        .cm_interrupt(cm_interrupt), .cm_inst_addr_err(cm_inst_addr_err),
        .cm_no_inst(cm_no_inst), .cm_syscall(cm_syscall), .cm_break(cm_break),
        .cm_ov(cm_ov), .cm_load_addr_err(cm_load_addr_err),
        .cm_store_addr_err(cm_store_addr_err), .cm_data_addr(cm_data_addr),
        .cm_eret(cm_eret), .cm_mtc0(cm_mtc0), .cm_cp0_addr(cm_cp0_addr),
        .cm_wdata(cm_wdata), .hw_int(hw_int),
        .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_compare(cp0_compare),
        .cp0_count(cp0_count), .cp0_epc(cp0_epc), .cp0_badvaddr(cp0_badvaddr),
        .int_req(int_req), .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_STATUS:   return cp0_status;
            SEL_CAUSE:    return cp0_cause;
            SEL_COMPARE:  return cp0_compare;
            SEL_COUNT:    return cp0_count;
            SEL_EPC:      return cp0_epc;
            SEL_BADVADDR: return cp0_badvaddr;
            SEL_INTREQ:   return {31'd0, int_req};
            SEL_FLUSH:    return {31'd0, flush};
            SEL_FLUSHPC:  return flush_pc;
            SEL_TI:       return {31'd0, cp0_cause[30]};
            SEL_IP15:     return {31'd0, cp0_cause[15]};
            default:      return 32'hxxxxxxxx;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check_q();
        exp_t        e;
        logic [31:0] got;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = observe(e.sel);
            checks++;
            assert (got === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, got, e.exp);
            end
        end
    endtask

    task automatic clear_cm();
        cm_valid = 0; cm_bd = 0; cm_interrupt = 0; cm_inst_addr_err = 0; cm_no_inst = 0;
        cm_syscall = 0; cm_break = 0; cm_ov = 0; cm_load_addr_err = 0;
        cm_store_addr_err = 0; cm_eret = 0; cm_mtc0 = 0;
        cm_pc = 32'd0; cm_data_addr = 32'd0; cm_wdata = 32'd0; cm_cp0_addr = 5'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        cm_valid = 1; cm_mtc0 = 1; cm_cp0_addr = addr; cm_wdata = data;
        step();
        clear_cm();
    endtask

    initial begin : stim
        bit ti_seen;
        clear_cm();
        hw_int = 6'd0;
        resetn = 1'b0;
        // Exception flags during reset must not flush.
        cm_valid = 1; cm_syscall = 1; cm_pc = 32'hbfc00000;
        repeat (2) @(posedge clk);
        #1;
        expect_val("rst_flush",    SEL_FLUSH,    32'd0);
        expect_val("rst_status",   SEL_STATUS,   32'h00400000);
        expect_val("rst_cause",    SEL_CAUSE,    32'd0);
        expect_val("rst_compare",  SEL_COMPARE,  32'd0);
        expect_val("rst_count",    SEL_COUNT,    32'd0);
        expect_val("rst_epc",      SEL_EPC,      32'd0);
        expect_val("rst_badvaddr", SEL_BADVADDR, 32'd0);
        expect_val("rst_intreq",   SEL_INTREQ,   32'd0);
        expect_val("rst_flushpc",  SEL_FLUSHPC,  C_VEC);
        check_q();
        clear_cm();
        resetn = 1'b1;

        // Syscall
        cm_valid = 1; cm_syscall = 1; cm_pc = 32'hbfc00100;
        #1;
        expect_val("sys_flush",   SEL_FLUSH,   32'd1);
        expect_val("sys_flushpc", SEL_FLUSHPC, C_VEC);
        check_q();
        step(); clear_cm();
        expect_val("sys_epc",    SEL_EPC,    32'hbfc00100);
        expect_val("sys_cause",  SEL_CAUSE,  32'h00000020);
        expect_val("sys_status", SEL_STATUS, 32'h00400002);
        check_q();

        // Fetch AdEL in a delay slot, then a nested Bp while EXL=1
        mtc0(5'd12, 32'h0);
        cm_valid = 1; cm_inst_addr_err = 1; cm_bd = 1; cm_pc = 32'hbfc00202;
        step(); clear_cm();
        expect_val("adel_epc",   SEL_EPC,      32'hbfc001fe);
        expect_val("adel_cause", SEL_CAUSE,    32'h80000010);
        expect_val("adel_bad",   SEL_BADVADDR, 32'hbfc00202);
        check_q();
        cm_valid = 1; cm_break = 1; cm_pc = 32'hbfc00300;
        step(); clear_cm();
        expect_val("nest_epc",   SEL_EPC,      32'hbfc001fe);
        expect_val("nest_cause", SEL_CAUSE,    32'h80000024);
        expect_val("nest_bad",   SEL_BADVADDR, 32'hbfc00202);
        check_q();

        // ERET
        mtc0(5'd14, 32'hbfc00400);
        cm_valid = 1; cm_eret = 1;
        #1;
        expect_val("eret_flush",   SEL_FLUSH,   32'd1);
        expect_val("eret_flushpc", SEL_FLUSHPC, 32'hbfc00400);
        check_q();
        step(); clear_cm();
        expect_val("eret_status", SEL_STATUS, 32'h00400000);
        check_q();

        // Exception and ERET together: exception wins
        cm_valid = 1; cm_eret = 1; cm_ov = 1; cm_pc = 32'hbfc00480;
        #1;
        expect_val("exeret_flushpc", SEL_FLUSHPC, C_VEC);
        check_q();
        step(); clear_cm();
        expect_val("exeret_status", SEL_STATUS, 32'h00400002);
        expect_val("exeret_epc",    SEL_EPC,    32'hbfc00480);
        expect_val("exeret_cause",  SEL_CAUSE,  32'h00000030);
        check_q();

        // MTC0 EPC on an excepting instruction is dropped
        mtc0(5'd12, 32'h0);
        cm_valid = 1; cm_mtc0 = 1; cm_cp0_addr = 5'd14; cm_wdata = 32'h1234;
        cm_syscall = 1; cm_pc = 32'hbfc00500;
        step(); clear_cm();
        expect_val("mtcexc_epc",   SEL_EPC,   32'hbfc00500);
        expect_val("mtcexc_cause", SEL_CAUSE, 32'h00000020);
        check_q();

        // cm_valid=0 ignores flags
        cm_syscall = 1; cm_pc = 32'hbfc00600;
        #1;
        expect_val("inval_flush", SEL_FLUSH, 32'd0);
        check_q();
        step(); clear_cm();
        expect_val("inval_epc", SEL_EPC, 32'hbfc00500);
        check_q();

        // BADVADDR is read-only; AdES loads it from the data address
        mtc0(5'd8, 32'hdeadbeef);
        expect_val("bad_ro", SEL_BADVADDR, 32'hbfc00202);
        check_q();
        cm_valid = 1; cm_store_addr_err = 1; cm_data_addr = 32'h11112223; cm_pc = 32'hbfc00640;
        step(); clear_cm();
        expect_val("ades_bad",   SEL_BADVADDR, 32'h11112223);
        expect_val("ades_cause", SEL_CAUSE,    32'h00000014);
        expect_val("ades_epc",   SEL_EPC,      32'hbfc00500);
        check_q();

        // Timer interrupt: TI appears exactly as COUNT reaches COMPARE
        mtc0(5'd12, 32'h0);
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'd5);
        mtc0(5'd12, 32'h00008001);
        ti_seen = 1'b0;
        for (int i = 0; i < 40 && !ti_seen; i++) begin
            step();
            ti_seen = cp0_cause[30];
        end
        expect_val("tmr_ti",     SEL_TI,     32'd1);
        expect_val("tmr_count",  SEL_COUNT,  32'd5);
        expect_val("tmr_ip15",   SEL_IP15,   32'd1);
        expect_val("tmr_intreq", SEL_INTREQ, 32'd1);
        expect_val("tmr_status", SEL_STATUS, 32'h00408001);
        check_q();
        mtc0(5'd11, 32'd20);
        expect_val("tmr_clr_ti",      SEL_TI,      32'd0);
        expect_val("tmr_clr_intreq",  SEL_INTREQ,  32'd0);
        expect_val("tmr_clr_compare", SEL_COMPARE, 32'd20);
        check_q();

        // Hardware interrupt line, one-cycle sampling latency, then taken
        mtc0(5'd12, 32'h00000401);
        hw_int = 6'b000001;
        #1;
        expect_val("hw_int_lat", SEL_INTREQ, 32'd0);
        check_q();
        step();
        expect_val("hw_int_req", SEL_INTREQ, 32'd1);
        check_q();
        cm_valid = 1; cm_interrupt = 1; cm_pc = 32'hbfc00700;
        step(); clear_cm();
        expect_val("int_cause",  SEL_CAUSE,  32'h00000400);
        expect_val("int_epc",    SEL_EPC,    32'hbfc00700);
        expect_val("int_masked", SEL_INTREQ, 32'd0);
        check_q();
        hw_int = 6'd0;

        // COUNT wraparound
        mtc0(5'd9, 32'hffffffff);
        expect_val("wrap_load", SEL_COUNT, 32'hffffffff);
        check_q();
        step();
        step();
        expect_val("wrap_zero", SEL_COUNT, 32'd0);
        check_q();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
